m_scroll_disp: RTL

Parametrised scrolling-text driver for a multiplexed common-anode 7-segment display. It holds `N_MSG` fixed messages of `MSG_LEN` characters each and shows an `N_DIGITS`-wide window of the selected message. The window advances one character per step period, left or right, and the digits are time-multiplexed. It sits between the board switches/clock and the display pins and replaces the single-message fixed-address ROM plus free-running 1 s prescaler arrangement.

---
 rtl/disp_pkg.sv | 49 ++++
 rtl/m_msg_rom.sv | 24 ++
 rtl/m_scroll_disp.sv | 118 +++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Segment patterns and message contents shared by the scrolling display driver.
// Patterns are active-low: bit7 = dp, bits6..0 = g..a.
package disp_pkg;

  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_O     = 8'hC0;
  localparam logic [7:0] SEG_G     = 8'hC2;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_Y     = 8'h91;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int N_TABLE_MSG = 2;

  // Each message is an 8-character phrase stored twice, so addresses fold modulo 8.
  function automatic logic [7:0] msg_char(input int unsigned m, input int unsigned a);
    logic [7:0] c;
    c = SEG_BLANK;
    case (m)
      32'd0: begin
        case (a & 32'd7)
          32'd0:   c = SEG_H;
          32'd1:   c = SEG_E;
          32'd2:   c = SEG_L;
          32'd3:   c = SEG_L;
          32'd4:   c = SEG_O;
          default: c = SEG_BLANK;
        endcase
      end
      32'd1: begin
        case (a & 32'd7)
          32'd0:   c = SEG_G;
          32'd1:   c = SEG_O;
          32'd2:   c = SEG_O;
          32'd3:   c = SEG_D;
          32'd4:   c = SEG_B;
          32'd5:   c = SEG_Y;
          32'd6:   c = SEG_E;
          default: c = SEG_BLANK;
        endcase
      end
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/m_msg_rom.sv
// Combinational message ROM: (message index, character address) -> segment pattern.
module m_msg_rom
  import disp_pkg::*;
#(
  parameter int N_MSG = 2,
  parameter int MSW   = 1,
  parameter int AW    = 4
) (
  input  logic [MSW-1:0] msg,
  input  logic [AW-1:0]  addr,
  output logic [7:0]     seg
);

  // Indices beyond the built message count or the stored table read blank.
  always_comb begin
    seg = SEG_BLANK;
    if ((32'(msg) < N_MSG) && (32'(msg) < N_TABLE_MSG)) begin
      seg = msg_char(32'(msg), 32'(addr));
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/m_scroll_disp.sv
// Scrolling-text driver for a multiplexed common-anode 7-segment display:
// scroll step counter, message load, digit multiplexing and registered pin outputs.
module m_scroll_disp
  import disp_pkg::*;
#(
  parameter int N_MSG    = 2,
  parameter int MSG_LEN  = 16,
  parameter int N_DIGITS = 4,
  parameter int STEP_DIV = 50_000_000,
  parameter int MUX_DIV  = 50_000,
  localparam int MSW     = (N_MSG > 1) ? $clog2(N_MSG) : 1,
  localparam int AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MSW-1:0]      msg_sel,
  input  logic                run,
  input  logic                dir,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic [AW-1:0]       pos,
  output logic                step
);

  localparam int SCW = $clog2(STEP_DIV);
  localparam int MCW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int DW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [MSW-1:0]      cur_msg_r;
  logic [AW-1:0]       pos_r;
  logic [SCW-1:0]      step_cnt_r;
  logic [MCW-1:0]      mux_cnt_r;
  logic [DW-1:0]       dig_r;
  logic [7:0]          seg_r;
  logic [N_DIGITS-1:0] an_r;
  logic                step_r;

  logic [AW-1:0]       rom_addr_s;
  logic [7:0]          rom_seg_s;
  logic [N_DIGITS-1:0] an_s;
  logic [AW-1:0]       pos_next_s;
  logic                step_tick_s;
  logic                mux_wrap_s;

  // Next-state decode for the counters and the addressed character.
  always_comb begin
    rom_addr_s  = pos_r + AW'(dig_r);
    an_s        = ~(N_DIGITS'(1'b1) << dig_r);
    step_tick_s = run && (step_cnt_r == SCW'(STEP_DIV - 1));
    mux_wrap_s  = (mux_cnt_r == MCW'(MUX_DIV - 1));
    if (dir) begin
      pos_next_s = pos_r - AW'(1'b1);
    end else begin
      pos_next_s = pos_r + AW'(1'b1);
    end
  end

  m_msg_rom #(
    .N_MSG (N_MSG),
    .MSW   (MSW),
    .AW    (AW)
  ) u_rom (
    .msg  (cur_msg_r),
    .addr (rom_addr_s),
    .seg  (rom_seg_s)
  );

  // Counters, message load and the registered display/step outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_msg_r  <= '0;
      pos_r      <= '0;
      step_cnt_r <= '0;
      mux_cnt_r  <= '0;
      dig_r      <= '0;
      seg_r      <= SEG_BLANK;
      an_r       <= '1;
      step_r     <= 1'b0;
    end else begin
      seg_r <= rom_seg_s;
      an_r  <= an_s;

      if (mux_wrap_s) begin
        mux_cnt_r <= '0;
        if (dig_r == DW'(N_DIGITS - 1)) begin
          dig_r <= '0;
        end else begin
          dig_r <= dig_r + DW'(1'b1);
        end
      end else begin
        mux_cnt_r <= mux_cnt_r + MCW'(1'b1);
      end

      // A message change swallows any step tick in the same cycle.
      if (msg_sel != cur_msg_r) begin
        cur_msg_r  <= msg_sel;
        pos_r      <= '0;
        step_cnt_r <= '0;
        step_r     <= 1'b0;
      end else if (step_tick_s) begin
        step_cnt_r <= '0;
        pos_r      <= pos_next_s;
        step_r     <= 1'b1;
      end else if (run) begin
        step_cnt_r <= step_cnt_r + SCW'(1'b1);
        step_r     <= 1'b0;
      end else begin
        step_r     <= 1'b0;
      end
    end
  end

  assign seg  = seg_r;
  assign an   = an_r;
  assign pos  = pos_r;
  assign step = step_r;

endmodule
